ibex_rf_wb_arbiter: RTL and testbench

- Writeback stage directly upstream of the integer register file write port.
- Merges two write sources onto the single register-file write port: EX-stage results (single-cycle, stallable) and LSU load responses (multi-cycle, non-stallable).
- Buffers displaced EX writes in a skid FIFO and tracks outstanding load destinations.
- Exports a per-register pending vector so ID can stall on RAW/WAW hazards.

---
 rtl/ibex_rf_wb_arbiter_pkg.sv | 17 +
 rtl/ibex_rf_wb_arbiter_fifo.sv | 62 ++++++
 rtl/ibex_rf_wb_arbiter.sv | 134 +++++++++++++
 tb/tb_ibex_rf_wb_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/ibex_rf_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package ibex_rf_wb_arbiter_pkg;

  localparam int unsigned RfAddrW = 5;
  localparam int unsigned RfDataW = 32;

  // Default-width write record; the arbiter builds the same layout at its DataWidth.
  typedef struct packed {
    logic [RfAddrW-1:0] addr;
    logic [RfDataW-1:0] data;
  } rf_wr_t;

  function automatic int unsigned num_words(input bit rv32e);
    return rv32e ? 32'd16 : 32'd32;
  endfunction

endpackage

// File: rtl/ibex_rf_wb_arbiter_fifo.sv
// Shift-style synchronous FIFO; slot 0 is always the head, slots below the
// occupancy count are valid. Exposes the top KeyW bits of every slot.
module ibex_rf_wb_arbiter_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 2,
  parameter int unsigned KeyW  = Width
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [Width-1:0]      wdata_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [Width-1:0]      head_o,
  output logic [Depth-1:0]      valid_o,
  output logic [Depth*KeyW-1:0] key_o
);

  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [CntW-1:0]  cnt_q, cnt_d;

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[0];

  // Push lands behind the post-pop occupancy, so push+pop keeps order.
  always_comb begin
    mem_d = mem_q;
    cnt_d = cnt_q;
    if (pop_i && !empty_o) begin
      for (int i = 0; i < int'(Depth) - 1; i++) mem_d[i] = mem_q[i+1];
      cnt_d = cnt_d - CntW'(1);
    end
    if (push_i && !full_o) begin
      for (int i = 0; i < int'(Depth); i++) begin
        if (CntW'(i) == cnt_d) mem_d[i] = wdata_i;
      end
      cnt_d = cnt_d + CntW'(1);
    end
  end

  always_comb begin
    for (int i = 0; i < int'(Depth); i++) begin
      valid_o[i]            = (CntW'(i) < cnt_q);
      key_o[i*KeyW +: KeyW] = mem_q[i][Width-1 -: KeyW];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/ibex_rf_wb_arbiter.sv
// Writeback arbiter: merges non-stallable load responses and stallable EX
// results onto the single register-file write port, with hazard tracking.
module ibex_rf_wb_arbiter
  import ibex_rf_wb_arbiter_pkg::*;
#(
  parameter bit          RV32E       = 1'b0,
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned ExFifoDepth = 2,
  parameter int unsigned LoadDepth   = 2,
  localparam int unsigned NUM_WORDS  = RV32E ? 16 : 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 ex_we_i,
  input  logic [RfAddrW-1:0]   ex_waddr_i,
  input  logic [DataWidth-1:0] ex_wdata_i,
  output logic                 ex_ready_o,
  input  logic                 lsu_req_i,
  input  logic [RfAddrW-1:0]   lsu_rd_i,
  input  logic                 lsu_rvalid_i,
  input  logic [DataWidth-1:0] lsu_rdata_i,
  input  logic                 lsu_err_i,
  output logic                 rf_we_o,
  output logic [RfAddrW-1:0]   rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  output logic [NUM_WORDS-1:0] pending_o,
  output logic                 err_o
);

  typedef struct packed {
    logic [RfAddrW-1:0]   addr;
    logic [DataWidth-1:0] data;
  } ex_wr_t;

  localparam int unsigned ExW = $bits(ex_wr_t);

  ex_wr_t                         ex_in, ex_head;
  logic                           ex_full, ex_empty, ex_push, ex_pop;
  logic [ExFifoDepth-1:0]         ex_vld;
  logic [ExFifoDepth*RfAddrW-1:0] ex_keys;
  logic [RfAddrW-1:0]             lq_head;
  logic                           lq_full, lq_empty, lq_push;
  logic [LoadDepth-1:0]           lq_vld;
  logic [LoadDepth*RfAddrW-1:0]   lq_keys;

  logic ex_addr_bad, ld_addr_bad, ex_keep, ld_wr, ex_direct;
  logic                 rf_we_q, rf_we_d, err_q, err_d;
  logic [RfAddrW-1:0]   rf_waddr_q, rf_waddr_d;
  logic [DataWidth-1:0] rf_wdata_q, rf_wdata_d;
  logic [NUM_WORDS-1:0] pend;
  logic                 hit;

  assign ex_addr_bad = RV32E && ex_we_i && ex_waddr_i[RfAddrW-1];
  assign ld_addr_bad = RV32E && lsu_req_i && lsu_rd_i[RfAddrW-1];

  // Readiness depends on current occupancy only; a same-cycle pop frees nothing.
  assign ex_ready_o = !ex_full;
  assign ex_keep    = ex_we_i && ex_ready_o && !ex_addr_bad && (ex_waddr_i != '0);
  assign ex_in      = '{addr: ex_waddr_i, data: ex_wdata_i};
  assign ex_push    = ex_keep && !ex_direct;

  assign lq_push = lsu_req_i && !ld_addr_bad && !lq_full;
  assign ld_wr   = lsu_rvalid_i && !lq_empty && !lsu_err_i && (lq_head != '0);

  ibex_rf_wb_arbiter_fifo #(.Width(ExW), .Depth(ExFifoDepth), .KeyW(RfAddrW)) u_ex_fifo (
    .clk_i(clk_i), .rst_i(rst_i), .push_i(ex_push), .pop_i(ex_pop), .wdata_i(ex_in),
    .full_o(ex_full), .empty_o(ex_empty), .head_o(ex_head), .valid_o(ex_vld), .key_o(ex_keys)
  );

  ibex_rf_wb_arbiter_fifo #(.Width(RfAddrW), .Depth(LoadDepth), .KeyW(RfAddrW)) u_load_q (
    .clk_i(clk_i), .rst_i(rst_i), .push_i(lq_push), .pop_i(lsu_rvalid_i), .wdata_i(lsu_rd_i),
    .full_o(lq_full), .empty_o(lq_empty), .head_o(lq_head), .valid_o(lq_vld), .key_o(lq_keys)
  );

  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    ex_pop     = 1'b0;
    ex_direct  = 1'b0;
    if (ld_wr) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = lq_head;
      rf_wdata_d = lsu_rdata_i;
    end else if (!ex_empty) begin
      ex_pop     = 1'b1;
      rf_we_d    = 1'b1;
      rf_waddr_d = ex_head.addr;
      rf_wdata_d = ex_head.data;
    end else if (ex_keep) begin
      ex_direct  = 1'b1;
      rf_we_d    = 1'b1;
      rf_waddr_d = ex_waddr_i;
      rf_wdata_d = ex_wdata_i;
    end
  end

  assign err_d = ex_addr_bad || ld_addr_bad || (lsu_req_i && lq_full) || (lsu_rvalid_i && lq_empty);

  always_comb begin
    pend = '0;
    hit  = 1'b0;
    for (int j = 1; j < int'(NUM_WORDS); j++) begin
      hit = rf_we_q && (rf_waddr_q == RfAddrW'(j));
      for (int e = 0; e < int'(ExFifoDepth); e++)
        hit = hit || (ex_vld[e] && (ex_keys[e*RfAddrW +: RfAddrW] == RfAddrW'(j)));
      for (int l = 0; l < int'(LoadDepth); l++)
        hit = hit || (lq_vld[l] && (lq_keys[l*RfAddrW +: RfAddrW] == RfAddrW'(j)));
      pend[j] = hit;
    end
  end

  assign pending_o = pend;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      err_q      <= 1'b0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      err_q      <= err_d;
    end
  end

  assign rf_we_o    = rf_we_q;
  assign rf_waddr_o = rf_waddr_q;
  assign rf_wdata_o = rf_wdata_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_ibex_rf_wb_arbiter.sv
// Bench for ibex_rf_wb_arbiter (RV32E=1, depths 2): directed vector table,
// queue-based reference model for random traffic, and an async-reset sequence.
module tb_ibex_rf_wb_arbiter;

  localparam int EXD = 2;
  localparam int LDD = 2;
  localparam int NW  = 16;

  logic          clk;
  logic          rst_i;
  logic          ex_we_i, lsu_req_i, lsu_rvalid_i, lsu_err_i;
  logic [4:0]    ex_waddr_i, lsu_rd_i;
  logic [31:0]   ex_wdata_i, lsu_rdata_i;
  logic          ex_ready_o, rf_we_o, err_o;
  logic [4:0]    rf_waddr_o;
  logic [31:0]   rf_wdata_o;
  logic [NW-1:0] pending_o;

  ibex_rf_wb_arbiter #(.RV32E(1'b1), .DataWidth(32), .ExFifoDepth(EXD), .LoadDepth(LDD)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .ex_we_i(ex_we_i), .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i), .ex_ready_o(ex_ready_o),
    .lsu_req_i(lsu_req_i), .lsu_rd_i(lsu_rd_i), .lsu_rvalid_i(lsu_rvalid_i),
    .lsu_rdata_i(lsu_rdata_i), .lsu_err_i(lsu_err_i),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .pending_o(pending_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic        ex_we; logic [4:0] ex_a; logic [31:0] ex_d;
    logic        req;   logic [4:0] rd;
    logic        rv;    logic [31:0] rdat; logic rerr;
    logic        e_rdy; logic e_we; logic [4:0] e_a; logic [31:0] e_d; logic e_err;
    logic [15:0] e_pend;
  } vec_t;

  typedef struct { logic [4:0] a; logic [31:0] d; } wr_t;

  // Reference model: pending writes as plain queues plus the visible output.
  wr_t         m_exq[$];
  logic [4:0]  m_lq[$];
  logic        m_we, m_err;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  task automatic m_reset();
    m_exq.delete(); m_lq.delete();
    m_we = 0; m_err = 0; m_addr = 0; m_data = 0;
  endtask

  function automatic logic [15:0] m_pending();
    logic [15:0] p = '0;
    foreach (m_exq[i]) p[m_exq[i].a[3:0]] = 1'b1;
    foreach (m_lq[i])  p[m_lq[i][3:0]]    = 1'b1;
    if (m_we) p[m_addr[3:0]] = 1'b1;
    p[0] = 1'b0;
    return p;
  endfunction

  task automatic m_step(input vec_t v);
    int  exn = m_exq.size();
    int  lqn = m_lq.size();
    bit  ex_ok, ld_wr;
    wr_t w;
    ex_ok = v.ex_we && (exn < EXD) && (v.ex_a < 16) && (v.ex_a != 0);
    ld_wr = v.rv && (lqn > 0) && !v.rerr && (m_lq[0] != 0);
    m_err = (v.ex_we && v.ex_a >= 16) || (v.req && v.rd >= 16) ||
            (v.req && lqn == LDD) || (v.rv && lqn == 0);
    m_we = 1;
    if (ld_wr) begin
      m_addr = m_lq[0]; m_data = v.rdat;
    end else if (exn > 0) begin
      w = m_exq.pop_front(); m_addr = w.a; m_data = w.d;
    end else if (ex_ok) begin
      m_addr = v.ex_a; m_data = v.ex_d; ex_ok = 0;
    end else begin
      m_we = 0;
    end
    if (ex_ok) m_exq.push_back('{a: v.ex_a, d: v.ex_d});
    if (v.rv && lqn > 0) void'(m_lq.pop_front());
    if (v.req && v.rd < 16 && lqn < LDD) m_lq.push_back(v.rd);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    ex_we_i = 0; ex_waddr_i = 0; ex_wdata_i = 0;
    lsu_req_i = 0; lsu_rd_i = 0; lsu_rvalid_i = 0; lsu_rdata_i = 0; lsu_err_i = 0;
  endtask

  task automatic cycle(input vec_t v, input bit use_model, input string tag);
    @(negedge clk);
    ex_we_i = v.ex_we; ex_waddr_i = v.ex_a; ex_wdata_i = v.ex_d;
    lsu_req_i = v.req; lsu_rd_i = v.rd;
    lsu_rvalid_i = v.rv; lsu_rdata_i = v.rdat; lsu_err_i = v.rerr;
    #1;
    if (use_model) v.e_rdy = (m_exq.size() < EXD);
    chk({tag, ".ex_ready"}, 32'(ex_ready_o), 32'(v.e_rdy));
    m_step(v);
    @(posedge clk);
    #1;
    if (use_model) begin
      v.e_we = m_we; v.e_a = m_addr; v.e_d = m_data; v.e_err = m_err; v.e_pend = m_pending();
    end
    chk({tag, ".rf_we"},   32'(rf_we_o),    32'(v.e_we));
    chk({tag, ".rf_waddr"}, 32'(rf_waddr_o), 32'(v.e_a));
    chk({tag, ".rf_wdata"}, rf_wdata_o,      v.e_d);
    chk({tag, ".err"},     32'(err_o),      32'(v.e_err));
    chk({tag, ".pending"}, 32'(pending_o),  32'(v.e_pend));
  endtask

  function automatic vec_t mk(logic ew, logic [4:0] ea, logic [31:0] ed,
                              logic rq, logic [4:0] rd, logic rv, logic [31:0] rdat, logic rerr,
                              logic erdy, logic ewe, logic [4:0] eaddr, logic [31:0] edata,
                              logic eerr, logic [15:0] epend);
    vec_t v;
    v.ex_we = ew; v.ex_a = ea; v.ex_d = ed; v.req = rq; v.rd = rd;
    v.rv = rv; v.rdat = rdat; v.rerr = rerr;
    v.e_rdy = erdy; v.e_we = ewe; v.e_a = eaddr; v.e_d = edata; v.e_err = eerr; v.e_pend = epend;
    return v;
  endfunction

  function automatic logic [4:0] rand_addr();
    return ($urandom_range(0, 15) == 0) ? 5'($urandom_range(16, 31)) : 5'($urandom_range(0, 15));
  endfunction

  vec_t tv[30];
  vec_t rv;

  initial begin
    // ex_we,a,d | req,rd | rv,rdata,err | exp: ready,we,addr,data,err,pending
    tv[0]  = mk(1, 1, 'h10, 0, 0, 0, 0, 0,            1, 1, 1, 'h10, 0, 'h0002);
    tv[1]  = mk(1, 2, 'h20, 0, 0, 0, 0, 0,            1, 1, 2, 'h20, 0, 'h0004);
    tv[2]  = mk(1, 3, 'h30, 0, 0, 0, 0, 0,            1, 1, 3, 'h30, 0, 'h0008);
    tv[3]  = mk(1, 4, 'h40, 0, 0, 0, 0, 0,            1, 1, 4, 'h40, 0, 'h0010);
    tv[4]  = mk(1, 5, 'h50, 0, 0, 0, 0, 0,            1, 1, 5, 'h50, 0, 'h0020);
    tv[5]  = mk(0, 0, 0,    0, 0, 0, 0, 0,            1, 0, 5, 'h50, 0, 'h0000);
    tv[6]  = mk(0, 0, 0,    1, 7, 0, 0, 0,            1, 0, 5, 'h50, 0, 'h0080);
    tv[7]  = mk(1, 3, 'h33, 0, 0, 1, 'hDEADBEEF, 0,   1, 1, 7, 'hDEADBEEF, 0, 'h0088);
    tv[8]  = mk(0, 0, 0,    0, 0, 0, 0, 0,            1, 1, 3, 'h33, 0, 'h0008);
    tv[9]  = mk(0, 0, 0,    0, 0, 0, 0, 0,            1, 0, 3, 'h33, 0, 'h0000);
    tv[10] = mk(0, 0, 0,    1, 10, 0, 0, 0,           1, 0, 3, 'h33, 0, 'h0400);
    tv[11] = mk(1, 1, 'h01, 1, 11, 1, 'hA0, 0,        1, 1, 10, 'hA0, 0, 'h0C02);
    tv[12] = mk(1, 2, 'h02, 1, 12, 1, 'hB0, 0,        1, 1, 11, 'hB0, 0, 'h1806);
    tv[13] = mk(1, 4, 'h04, 0, 0, 1, 'hC0, 0,         0, 1, 12, 'hC0, 0, 'h1006);
    tv[14] = mk(0, 0, 0,    0, 0, 0, 0, 0,            0, 1, 1, 'h01, 0, 'h0006);
    tv[15] = mk(1, 4, 'h04, 0, 0, 0, 0, 0,            1, 1, 2, 'h02, 0, 'h0014);
    tv[16] = mk(0, 0, 0,    0, 0, 0, 0, 0,            1, 1, 4, 'h04, 0, 'h0010);
    tv[17] = mk(0, 0, 0,    0, 0, 0, 0, 0,            1, 0, 4, 'h04, 0, 'h0000);
    tv[18] = mk(0, 0, 0,    1, 9, 0, 0, 0,            1, 0, 4, 'h04, 0, 'h0200);
    tv[19] = mk(0, 0, 0,    0, 0, 1, 'h99, 1,         1, 0, 4, 'h04, 0, 'h0000);
    tv[20] = mk(0, 0, 0,    1, 5, 0, 0, 0,            1, 0, 4, 'h04, 0, 'h0020);
    tv[21] = mk(0, 0, 0,    1, 6, 0, 0, 0,            1, 0, 4, 'h04, 0, 'h0060);
    tv[22] = mk(0, 0, 0,    1, 8, 0, 0, 0,            1, 0, 4, 'h04, 1, 'h0060);
    tv[23] = mk(0, 0, 0,    0, 0, 0, 0, 0,            1, 0, 4, 'h04, 0, 'h0060);
    tv[24] = mk(0, 0, 0,    0, 0, 1, 'h55, 0,         1, 1, 5, 'h55, 0, 'h0060);
    tv[25] = mk(0, 0, 0,    0, 0, 1, 'h66, 0,         1, 1, 6, 'h66, 0, 'h0040);
    tv[26] = mk(0, 0, 0,    0, 0, 1, 'h77, 0,         1, 0, 6, 'h66, 1, 'h0000);
    tv[27] = mk(1, 20, 'h77, 0, 0, 0, 0, 0,           1, 0, 6, 'h66, 1, 'h0000);
    tv[28] = mk(0, 0, 0,    0, 0, 0, 0, 0,            1, 0, 6, 'h66, 0, 'h0000);
    tv[29] = mk(1, 0, 'h99, 0, 0, 0, 0, 0,            1, 0, 6, 'h66, 0, 'h0000);

    rst_i = 1'b1;
    idle_inputs();
    m_reset();
    #3;
    chk("reset.rf_we",    32'(rf_we_o),   0);
    chk("reset.rf_waddr", 32'(rf_waddr_o), 0);
    chk("reset.rf_wdata", rf_wdata_o,      0);
    chk("reset.err",      32'(err_o),     0);
    chk("reset.pending",  32'(pending_o), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_i = 1'b0;

    for (int i = 0; i < 30; i++) cycle(tv[i], 1'b0, $sformatf("vec%0d", i));

    for (int i = 0; i < 400; i++) begin
      rv = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      rv.ex_we = 1'($urandom_range(0, 1));
      rv.ex_a  = rand_addr();
      rv.ex_d  = $urandom;
      rv.req   = ($urandom_range(0, 2) == 0);
      rv.rd    = rand_addr();
      rv.rv    = (m_lq.size() > 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 15) == 0);
      rv.rdat  = $urandom;
      rv.rerr  = ($urandom_range(0, 9) == 0);
      cycle(rv, 1'b1, $sformatf("rnd%0d", i));
    end

    // Fill both queues, then hit reset between clock edges.
    cycle(mk(0, 0, 0,    1, 3, 0, 0, 0,     0, 0, 0, 0, 0, 0), 1'b1, "fill0");
    cycle(mk(0, 0, 0,    1, 4, 1, 'h1, 1,   0, 0, 0, 0, 0, 0), 1'b1, "fill1");
    cycle(mk(0, 0, 0,    1, 11, 0, 0, 0,    0, 0, 0, 0, 0, 0), 1'b1, "fill2");
    cycle(mk(1, 5, 'h5A, 0, 0, 1, 'hE0, 0,  0, 0, 0, 0, 0, 0), 1'b1, "fill3");
    cycle(mk(1, 6, 'h6A, 1, 7, 1, 'hE1, 0,  0, 0, 0, 0, 0, 0), 1'b1, "fill4");
    #2;
    rst_i = 1'b1;
    #1;
    chk("async_rst.rf_we",    32'(rf_we_o),    0);
    chk("async_rst.rf_waddr", 32'(rf_waddr_o), 0);
    chk("async_rst.rf_wdata", rf_wdata_o,      0);
    chk("async_rst.err",      32'(err_o),      0);
    chk("async_rst.pending",  32'(pending_o),  0);
    chk("async_rst.ex_ready", 32'(ex_ready_o), 1);
    m_reset();
    idle_inputs();
    @(posedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    for (int i = 0; i < 4; i++)
      cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1, $sformatf("post_rst%0d", i));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
